// File: rtl/controller_pkg.sv
// Shared constants and types for the pad input conditioner:
// default sizing, channel indices and the per-edge filter decision encoding.
package controller_pkg;

   localparam int unsigned DEFAULT_SYNC_STAGES = 2;
   localparam int unsigned DEFAULT_CNT_WIDTH   = 4;

   localparam int unsigned CH_RESET_N         = 0;
   localparam int unsigned CH_LATCH_DATA      = 1;
   localparam int unsigned CH_CONTROL_TRIGGER = 2;

   // What the filter does with the current sample at a clock edge.
   typedef enum logic [2:0] {
      ACT_FREEZE = 3'd0,
      ACT_MATCH  = 3'd1,
      ACT_FAST   = 3'd2,
      ACT_COMMIT = 3'd3,
      ACT_COUNT  = 3'd4
   } filter_action_e;

endpackage

// File: rtl/input_filter_channel.sv
// One conditioned channel: synchroniser chain, glitch filter counter,
// filtered level register and registered rise/fall pulses.
module input_filter_channel
   import controller_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = DEFAULT_SYNC_STAGES,
   parameter int unsigned CNT_WIDTH    = DEFAULT_CNT_WIDTH,
   parameter logic        IDLE_LEVEL   = 1'b0,
   parameter logic        FAST_RELEASE = 1'b0
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 raw,
   input  logic                 enable,
   input  logic [CNT_WIDTH-1:0] filter_len,
   output logic                 level,
   output logic                 rise_pulse,
   output logic                 fall_pulse
);

   // The level/counter registers form the last synchroniser stage, so the
   // explicit chain is one flop shorter than SYNC_STAGES.
   localparam int unsigned CHAIN = SYNC_STAGES - 1;

   logic [CHAIN-1:0]     sync_r;
   logic                 synced_s;
   logic                 level_r;
   logic                 rise_r;
   logic                 fall_r;
   logic [CNT_WIDTH-1:0] count_r;
   logic [CNT_WIDTH:0]   count_inc_s;
   logic [CNT_WIDTH:0]   len_eff_s;
   filter_action_e       action_s;
   logic                 level_nxt_s;
   logic [CNT_WIDTH-1:0] count_nxt_s;
   logic                 rise_nxt_s;
   logic                 fall_nxt_s;

   function automatic logic [CNT_WIDTH:0] eff_len(input logic [CNT_WIDTH-1:0] len);
      logic [CNT_WIDTH:0] r;
      if (len == {CNT_WIDTH{1'b0}}) begin
         r = {{CNT_WIDTH{1'b0}}, 1'b1};
      end else begin
         r = {1'b0, len};
      end
      return r;
   endfunction

   // Synchroniser chain, shifts regardless of enable
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= {CHAIN{IDLE_LEVEL}};
      end else begin
         sync_r[0] <= raw;
         for (int i = 1; i < int'(CHAIN); i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   assign synced_s    = sync_r[CHAIN-1];
   assign count_inc_s = {1'b0, count_r} + {{CNT_WIDTH{1'b0}}, 1'b1};
   assign len_eff_s   = eff_len(filter_len);

   // Classify this edge; >= lets a lowered filter_len act immediately
   always_comb begin
      action_s = ACT_FREEZE;
      if (!enable) begin
         action_s = ACT_FREEZE;
      end else if (synced_s == level_r) begin
         action_s = ACT_MATCH;
      end else if (FAST_RELEASE && (synced_s == IDLE_LEVEL)) begin
         action_s = ACT_FAST;
      end else if (count_inc_s >= len_eff_s) begin
         action_s = ACT_COMMIT;
      end else begin
         action_s = ACT_COUNT;
      end
   end

   // Next level/counter; ACT_COUNT only occurs below len_eff, so no wrap
   always_comb begin
      level_nxt_s = level_r;
      count_nxt_s = {CNT_WIDTH{1'b0}};
      case (action_s)
         ACT_FREEZE: begin
            level_nxt_s = level_r;
            count_nxt_s = {CNT_WIDTH{1'b0}};
         end
         ACT_MATCH: begin
            level_nxt_s = level_r;
            count_nxt_s = {CNT_WIDTH{1'b0}};
         end
         ACT_FAST, ACT_COMMIT: begin
            level_nxt_s = synced_s;
            count_nxt_s = {CNT_WIDTH{1'b0}};
         end
         ACT_COUNT: begin
            level_nxt_s = level_r;
            count_nxt_s = count_inc_s[CNT_WIDTH-1:0];
         end
         default: begin
            level_nxt_s = level_r;
            count_nxt_s = {CNT_WIDTH{1'b0}};
         end
      endcase
   end

   // Pulses track the change committed at this same edge
   always_comb begin
      rise_nxt_s = 1'b0;
      fall_nxt_s = 1'b0;
      if (level_nxt_s != level_r) begin
         rise_nxt_s = level_nxt_s;
         fall_nxt_s = ~level_nxt_s;
      end else begin
         rise_nxt_s = 1'b0;
         fall_nxt_s = 1'b0;
      end
   end

   // Filter state and pulse registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         level_r <= IDLE_LEVEL;
         count_r <= {CNT_WIDTH{1'b0}};
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
      end else begin
         level_r <= level_nxt_s;
         count_r <= count_nxt_s;
         rise_r  <= rise_nxt_s;
         fall_r  <= fall_nxt_s;
      end
   end

   assign level      = level_r;
   assign rise_pulse = rise_r;
   assign fall_pulse = fall_r;

endmodule

// File: rtl/input_conditioner_array.sv
// N-channel pad input conditioner: LA override mux in front of independent
// synchronise / glitch-filter / edge-pulse channels.
module input_conditioner_array
   import controller_pkg::*;
#(
   parameter int unsigned           NUM_INPUTS   = 3,
   parameter int unsigned           SYNC_STAGES  = DEFAULT_SYNC_STAGES,
   parameter int unsigned           CNT_WIDTH    = DEFAULT_CNT_WIDTH,
   parameter logic [NUM_INPUTS-1:0] IDLE_LEVEL   = 3'b001,
   parameter logic [NUM_INPUTS-1:0] FAST_RELEASE = 3'b111
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [NUM_INPUTS-1:0] io_in,
   input  logic [NUM_INPUTS-1:0] la_data_in,
   input  logic [NUM_INPUTS-1:0] la_oenb,
   input  logic [NUM_INPUTS-1:0] chan_enable,
   input  logic [CNT_WIDTH-1:0]  filter_len,
   output logic [NUM_INPUTS-1:0] level_out,
   output logic [NUM_INPUTS-1:0] rise_pulse,
   output logic [NUM_INPUTS-1:0] fall_pulse
);

   logic [NUM_INPUTS-1:0] raw_s;

   if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
      $error("input_conditioner_array: SYNC_STAGES must be 2..4");
   end

   // Override mux; a source switch is just another input change downstream
   always_comb begin
      raw_s = {NUM_INPUTS{1'b0}};
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
         if (la_oenb[i]) begin
            raw_s[i] = io_in[i];
         end else begin
            raw_s[i] = la_data_in[i];
         end
      end
   end

   for (genvar g = 0; g < int'(NUM_INPUTS); g++) begin : g_chan
      input_filter_channel #(
         .SYNC_STAGES  (SYNC_STAGES),
         .CNT_WIDTH    (CNT_WIDTH),
         .IDLE_LEVEL   (IDLE_LEVEL[g]),
         .FAST_RELEASE (FAST_RELEASE[g])
      ) u_chan (
         .clock      (clock),
         .reset_n    (reset_n),
         .raw        (raw_s[g]),
         .enable     (chan_enable[g]),
         .filter_len (filter_len),
         .level      (level_out[g]),
         .rise_pulse (rise_pulse[g]),
         .fall_pulse (fall_pulse[g])
      );
   end

endmodule

// File: tb/tb_input_conditioner_array.sv
// Cycle-table bench for input_conditioner_array: each row is the inputs held
// across one clock edge and the outputs expected just after that edge.
module tb_input_conditioner_array;

   logic       clock;
   logic       reset_n;
   logic [2:0] io_in;
   logic [2:0] la_data_in;
   logic [2:0] la_oenb;
   logic [2:0] chan_enable;
   logic [3:0] filter_len;
   logic [2:0] level_out;
   logic [2:0] rise_pulse;
   logic [2:0] fall_pulse;

   typedef struct {
      logic [2:0] io;
      logic [2:0] la;
      logic [2:0] oenb;
      logic [2:0] en;
      logic [3:0] len;
      logic [2:0] exp_level;
      logic [2:0] exp_rise;
      logic [2:0] exp_fall;
   } vec_t;

   vec_t vecs[$];
   int   applied = 0;
   int   miscompares = 0;

   input_conditioner_array dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .io_in       (io_in),
      .la_data_in  (la_data_in),
      .la_oenb     (la_oenb),
      .chan_enable (chan_enable),
      .filter_len  (filter_len),
      .level_out   (level_out),
      .rise_pulse  (rise_pulse),
      .fall_pulse  (fall_pulse)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic add(input logic [2:0] io, input logic [2:0] la, input logic [2:0] oenb,
                      input logic [2:0] en, input logic [3:0] len, input logic [2:0] lvl,
                      input logic [2:0] rs, input logic [2:0] fl);
      vec_t v;
      v.io = io; v.la = la; v.oenb = oenb; v.en = en; v.len = len;
      v.exp_level = lvl; v.exp_rise = rs; v.exp_fall = fl;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [2:0] lvl,
                        input logic [2:0] rs, input logic [2:0] fl);
      applied++;
      if ({level_out, rise_pulse, fall_pulse} !== {lvl, rs, fl}) begin
         miscompares++;
         $display("FAIL %s: got level=%b rise=%b fall=%b, want level=%b rise=%b fall=%b",
                  name, level_out, rise_pulse, fall_pulse, lvl, rs, fl);
      end
   endtask

   initial begin
      // Reset released with idle inputs: no activity at all
      for (int i = 0; i < 10; i++) add(3'b001, 3'b000, 3'b111, 3'b111, 4'd0, 3'b001, 3'b000, 3'b000);

      // Two-sample glitch on ch1 with L=3: count reaches 2, then restarts
      add(3'b011, 3'b000, 3'b111, 3'b111, 4'd3, 3'b001, 3'b000, 3'b000);
      add(3'b011, 3'b000, 3'b111, 3'b111, 4'd3, 3'b001, 3'b000, 3'b000);
      add(3'b001, 3'b000, 3'b111, 3'b111, 4'd3, 3'b001, 3'b000, 3'b000);
      add(3'b001, 3'b000, 3'b111, 3'b111, 4'd3, 3'b001, 3'b000, 3'b000);
      add(3'b001, 3'b000, 3'b111, 3'b111, 4'd3, 3'b001, 3'b000, 3'b000);

      // Filtered assert on ch1: raw rises before edge 0, level at edge 3
      add(3'b011, 3'b000, 3'b111, 3'b111, 4'd3, 3'b001, 3'b000, 3'b000);
      add(3'b011, 3'b000, 3'b111, 3'b111, 4'd3, 3'b001, 3'b000, 3'b000);
      add(3'b011, 3'b000, 3'b111, 3'b111, 4'd3, 3'b001, 3'b000, 3'b000);
      add(3'b011, 3'b000, 3'b111, 3'b111, 4'd3, 3'b011, 3'b010, 3'b000);
      add(3'b011, 3'b000, 3'b111, 3'b111, 4'd3, 3'b011, 3'b000, 3'b000);

      // ch0 falls away from idle: needs L=3 samples
      add(3'b010, 3'b000, 3'b111, 3'b111, 4'd3, 3'b011, 3'b000, 3'b000);
      add(3'b010, 3'b000, 3'b111, 3'b111, 4'd3, 3'b011, 3'b000, 3'b000);
      add(3'b010, 3'b000, 3'b111, 3'b111, 4'd3, 3'b011, 3'b000, 3'b000);
      add(3'b010, 3'b000, 3'b111, 3'b111, 4'd3, 3'b010, 3'b000, 3'b001);
      add(3'b010, 3'b000, 3'b111, 3'b111, 4'd3, 3'b010, 3'b000, 3'b000);
      // ch0 returns to idle: fast release at edge k+1
      add(3'b011, 3'b000, 3'b111, 3'b111, 4'd3, 3'b010, 3'b000, 3'b000);
      add(3'b011, 3'b000, 3'b111, 3'b111, 4'd3, 3'b011, 3'b001, 3'b000);
      add(3'b011, 3'b000, 3'b111, 3'b111, 4'd3, 3'b011, 3'b000, 3'b000);

      // ch1 back to idle with filter_len=0, fast path
      add(3'b001, 3'b000, 3'b111, 3'b111, 4'd0, 3'b011, 3'b000, 3'b000);
      add(3'b001, 3'b000, 3'b111, 3'b111, 4'd0, 3'b001, 3'b000, 3'b010);
      add(3'b001, 3'b000, 3'b111, 3'b111, 4'd0, 3'b001, 3'b000, 3'b000);

      // LA override of ch1 to 1 while io_in[1]=0, then restore
      add(3'b001, 3'b010, 3'b101, 3'b111, 4'd0, 3'b001, 3'b000, 3'b000);
      add(3'b001, 3'b010, 3'b101, 3'b111, 4'd0, 3'b011, 3'b010, 3'b000);
      add(3'b001, 3'b010, 3'b101, 3'b111, 4'd0, 3'b011, 3'b000, 3'b000);
      add(3'b001, 3'b010, 3'b111, 3'b111, 4'd0, 3'b011, 3'b000, 3'b000);
      add(3'b001, 3'b010, 3'b111, 3'b111, 4'd0, 3'b001, 3'b000, 3'b010);
      add(3'b001, 3'b010, 3'b111, 3'b111, 4'd0, 3'b001, 3'b000, 3'b000);

      // ch2 disabled while its raw toggles: frozen
      add(3'b101, 3'b000, 3'b111, 3'b011, 4'd0, 3'b001, 3'b000, 3'b000);
      add(3'b001, 3'b000, 3'b111, 3'b011, 4'd0, 3'b001, 3'b000, 3'b000);
      add(3'b101, 3'b000, 3'b111, 3'b011, 4'd0, 3'b001, 3'b000, 3'b000);
      add(3'b101, 3'b000, 3'b111, 3'b011, 4'd0, 3'b001, 3'b000, 3'b000);

      // Re-enable with L=15: count to 5, then lower filter_len to 2
      for (int i = 0; i < 5; i++) add(3'b101, 3'b000, 3'b111, 3'b111, 4'd15, 3'b001, 3'b000, 3'b000);
      add(3'b101, 3'b000, 3'b111, 3'b111, 4'd2, 3'b101, 3'b100, 3'b000);
      add(3'b101, 3'b000, 3'b111, 3'b111, 4'd2, 3'b101, 3'b000, 3'b000);

      // All three channels change on the same edge with L=1
      add(3'b010, 3'b000, 3'b111, 3'b111, 4'd1, 3'b101, 3'b000, 3'b000);
      add(3'b010, 3'b000, 3'b111, 3'b111, 4'd1, 3'b010, 3'b010, 3'b101);

      reset_n     = 1'b0;
      io_in       = 3'b110;
      la_data_in  = 3'b000;
      la_oenb     = 3'b111;
      chan_enable = 3'b111;
      filter_len  = 4'd0;
      #12;
      check("reset_hold", 3'b001, 3'b000, 3'b000);
      io_in = 3'b001;
      @(negedge clock);
      reset_n = 1'b1;

      foreach (vecs[n]) begin
         io_in       = vecs[n].io;
         la_data_in  = vecs[n].la;
         la_oenb     = vecs[n].oenb;
         chan_enable = vecs[n].en;
         filter_len  = vecs[n].len;
         @(posedge clock);
         #1;
         check($sformatf("vec%0d", n), vecs[n].exp_level, vecs[n].exp_rise, vecs[n].exp_fall);
      end

      // Reset in the pulse cycle clears pulses and level at once
      reset_n = 1'b0;
      #1;
      check("reset_async", 3'b001, 3'b000, 3'b000);
      io_in = 3'b001;
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         check($sformatf("post_reset%0d", i), 3'b001, 3'b000, 3'b000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule

// File: doc/input_conditioner_array.md
Name: input_conditioner_array

Overview:
Parametrised successor to the fixed 2-stage sync/AND-OR filter used on the reset_n, latch_data and control_trigger pads. It has N independent channels. Each channel has:
- a logic-analyser override mux,
- a configurable-depth synchroniser,
- a programmable-length glitch filter with an optional fast-release path,
- an enable gate,
- registered rise and fall pulses.

It sits between the user IO and LA pins and the system_controller / backend_cycle_controller control inputs.

Parameters:
NUM_INPUTS, 3, number of conditioned channels
SYNC_STAGES, 2, synchroniser depth; legal range 2..4
CNT_WIDTH, 4, width of each filter counter and of filter_len
IDLE_LEVEL, 3'b001, per-channel reset and idle value (bit 0 = reset_n channel, idle high)
FAST_RELEASE, 3'b111, per-channel mask; 1 = transitions toward IDLE_LEVEL bypass the filter

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
io_in  input  NUM_INPUTS  raw pad inputs
la_data_in  input  NUM_INPUTS  LA override values
la_oenb  input  NUM_INPUTS  per channel: 0 selects la_data_in, 1 selects io_in
chan_enable  input  NUM_INPUTS  per channel: 0 freezes the channel
filter_len  input  CNT_WIDTH  consecutive-sample requirement, shared by all channels
level_out  output  NUM_INPUTS  filtered level
rise_pulse  output  NUM_INPUTS  one-cycle pulse on each 0->1 of level_out
fall_pulse  output  NUM_INPUTS  one-cycle pulse on each 1->0 of level_out

Behaviour:
- Reset (asynchronous, reset_n low):
  - all sync flops and level_out = IDLE_LEVEL
  - counters = 0
  - rise_pulse and fall_pulse = 0
  - on release, the first active edge is an ordinary edge; no pulses result from reset release
- Input mux: raw[i] = la_oenb[i] ? io_in[i] : la_data_in[i]. The mux is combinational and feeds sync stage 1. Override switching is treated as an ordinary input change.
- Synchroniser: SYNC_STAGES flops per channel. synced[i] is the last stage.
- Effective length: L = max(filter_len, 1).
- Filter, per channel, evaluated each edge while chan_enable[i] = 1:
  - synced == level: counter cleared to 0.
  - synced != level and FAST_RELEASE[i] = 1 and synced == IDLE_LEVEL[i]: level <= synced at this edge; counter cleared.
  - otherwise synced != level: if counter + 1 >= L, level <= synced and counter cleared; else counter increments.
  - A single sample equal to level restarts the count.
  - Because the compare is >=, lowering filter_len mid-count takes effect on the next edge.
  - The counter never exceeds 2^CNT_WIDTH - 1.
- Latency: raw changes and is stable before edge k, with no fast release. The first differing synced sample is seen at edge k + SYNC_STAGES - 1. level_out changes at edge k + SYNC_STAGES + L - 2.
  - SYNC_STAGES=2, L=1: change at edge k+1 after the first sync... i.e. a 2-cycle total path.
- Fast release: level_out changes at edge k + SYNC_STAGES - 1.
- Pulses:
  - rise_pulse[i] and fall_pulse[i] are registered. They are high for exactly the one cycle following the edge on which level_out[i] changed.
  - They are never both high on the same channel.
  - Pulse widths are independent per channel; simultaneous events on several channels are all reported.
- Disable (chan_enable[i] = 0):
  - sync flops keep shifting
  - level_out held
  - counter held at 0
  - pulses forced 0
  - on re-enable, normal filtering resumes against the held level
- Reset mid-count: counter and level return to reset values immediately; no pulse is generated.

Decomposition:
- Shared package controller_pkg holds:
  - default constants: DEFAULT_SYNC_STAGES=2, DEFAULT_CNT_WIDTH=4
  - channel index constants: CH_RESET_N=0, CH_LATCH_DATA=1, CH_CONTROL_TRIGGER=2
- Natural sub-module: input_filter_channel, covering one channel's sync chain, counter, level and pulse registers. It is instantiated NUM_INPUTS times via generate, with per-channel IDLE_LEVEL and FAST_RELEASE bits passed as 1-bit parameters.

Test Plan:
1. Reset: assert reset_n low with io_in=3'b110 -> level_out=3'b001, pulses 0. Release, hold io_in=3'b001 for 10 cycles -> no pulses.
2. Filtered assert: filter_len=3, channel 1 rises before edge 0 -> level_out[1]=1 at edge 3, rise_pulse[1] high for exactly cycle 3-4. A 2-cycle glitch on channel 1 -> no change.
3. Fast release: channel 0 held low long enough, then raw[0] rises before edge k -> level_out[0]=1 at edge k+1, rise_pulse[0] one cycle. The falling edge on channel 0 requires L samples.
4. LA override: la_oenb=3'b101, la_data_in[1]=1, io_in[1]=0, filter_len=0 -> level_out[1]=1 after the synchroniser delay. Restoring la_oenb[1]=1 -> level_out[1]=0 after the same delay.
5. Enable and filter_len: chan_enable[2]=0 while raw[2] toggles -> level_out[2] and pulses unchanged. With filter_len lowered from 15 to 2 mid-count (count=5) -> flip on the next edge.
6. Simultaneous: all three channels change at the same edge, filter_len=1 -> all pulses asserted in the same cycle. Reset asserted in that cycle -> pulses cleared immediately.
